// File: rtl/vector_loader.sv
// vector_loader: assembles streamed scalar elements into an N-lane vector and pulses vec_set to commit it
// Ports: clk/rst (sync active-high); start+len begin a load (len 0 or >N means N); abort cancels a fill;
// in_data/in_valid/in_ready element stream; vec_out lanes (lane i = i-th element); vec_set one-cycle commit;
// busy high in FILL and COMMIT; count elements accepted in the current load.
module vector_loader #(
  parameter int BITS = 8,
  parameter int N = 64,
  parameter int LEN_W = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic [BITS-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BITS-1:0]  vec_out [N-1:0],
  output logic             vec_set,
  output logic             busy,
  output logic [LEN_W-1:0] count
);
  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;
  state_t           state_q;
  logic [LEN_W-1:0] eff_q, count_q, count_d;
  logic [BITS-1:0]  lanes_q [N-1:0];
  logic             ready_q, set_q, busy_q;
  assign count_d  = count_q + 1'b1;
  assign in_ready = ready_q;
  assign vec_set  = set_q;
  assign busy     = busy_q;
  assign count    = count_q;
  assign vec_out  = lanes_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      eff_q   <= '0;
      count_q <= '0;
      lanes_q <= '{default: '0};
      ready_q <= 1'b0;
      set_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          eff_q   <= (len == '0 || len > LEN_W'(N)) ? LEN_W'(N) : len;
          count_q <= '0;
          lanes_q <= '{default: '0};
          state_q <= FILL;
          ready_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        FILL: if (abort) begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end else if (in_valid) begin
          lanes_q[count_q[LEN_W-2:0]] <= in_data;
          count_q <= count_d;
          if (count_d == eff_q) begin
            state_q <= COMMIT;
            ready_q <= 1'b0;
            set_q   <= 1'b1;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          set_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_loader.sv
// tb_vector_loader: directed stimulus with a per-cycle behavioural model and hand-computed literal checks
module tb_vector_loader;
  localparam int BITS = 8, N = 64, LW = $clog2(N) + 1;
  logic clk = 0, rst = 1, start = 0, abort = 0, in_valid = 0;
  logic in_ready, vec_set, busy;
  logic [LW-1:0] len = '0, count;
  logic [BITS-1:0] in_data = '0;
  logic [BITS-1:0] vec_out [N-1:0];
  logic [BITS-1:0] m_lanes [N-1:0];
  logic [BITS-1:0] cap [N-1:0];
  int m_cnt = 0, m_eff = 0;
  bit m_fill = 0, m_commit = 0;
  int checks = 0, failures = 0, edges = 0, pulses = 0;
  always #5 clk = ~clk;
  vector_loader #(.BITS(BITS), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .vec_out(vec_out), .vec_set(vec_set), .busy(busy), .count(count)
  );
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic int nonzero_lanes();
    int nb = 0;
    for (int i = 0; i < N; i++) if (vec_out[i] !== '0) nb++;
    return nb;
  endfunction
  always @(posedge clk) begin
    edges <= edges + 1;
    if (vec_set) begin
      pulses <= pulses + 1;
      cap <= vec_out;
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      m_fill <= 0;
      m_commit <= 0;
      m_cnt <= 0;
      for (int i = 0; i < N; i++) m_lanes[i] <= '0;
    end else if (m_commit) begin
      m_commit <= 0;
    end else if (m_fill) begin
      if (abort) m_fill <= 0;
      else if (in_valid) begin
        m_lanes[m_cnt] <= in_data;
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == m_eff) begin
          m_fill <= 0;
          m_commit <= 1;
        end
      end
    end else if (start) begin
      m_eff <= (int'(len) == 0 || int'(len) > N) ? N : int'(len);
      m_cnt <= 0;
      m_fill <= 1;
      for (int i = 0; i < N; i++) m_lanes[i] <= '0;
    end
  end
  always @(negedge clk) if (edges > 0) begin
    int nb;
    nb = 0;
    for (int i = 0; i < N; i++) if (vec_out[i] !== m_lanes[i]) nb++;
    chk("model_in_ready", 32'(in_ready), 32'(m_fill));
    chk("model_vec_set", 32'(vec_set), 32'(m_commit));
    chk("model_busy", 32'(busy), 32'(m_fill | m_commit));
    chk("model_count", 32'(count), 32'(m_cnt));
    chk("model_lane_mismatches", 32'(nb), 0);
  end
  initial begin
    int pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
    int exp_c [8] = '{1, 1, 1, 2, 3, 3, 4, 5};
    int s, nb, p;
    logic [BITS-1:0] d;
    repeat (2) cyc();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vec_set", 32'(vec_set), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_lanes", 32'(nonzero_lanes()), 0);
    rst = 0;
    cyc();
    len = 0; start = 1; cyc(); s = edges; start = 0;
    chk("full_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < N; i++) begin
      in_data = BITS'(i); in_valid = 1; cyc();
    end
    in_valid = 0;
    chk("full_set", 32'(vec_set), 1);
    chk("full_latency", 32'(edges - s), 64);
    chk("full_count", 32'(count), 64);
    nb = 0;
    for (int i = 0; i < N; i++) if (vec_out[i] !== BITS'(i)) nb++;
    chk("full_lanes", 32'(nb), 0);
    cyc();
    chk("full_busy_after", 32'(busy), 0);
    chk("full_set_after", 32'(vec_set), 0);
    nb = 0;
    for (int i = 0; i < N; i++) if (cap[i] !== BITS'(i)) nb++;
    chk("full_downstream", 32'(nb), 0);
    len = 5; start = 1; cyc(); start = 0;
    d = 8'hA1;
    for (int i = 0; i < 8; i++) begin
      in_valid = pat[i][0]; in_data = d; cyc();
      if (pat[i] == 1) d++;
      chk("part_count", 32'(count), 32'(exp_c[i]));
    end
    in_valid = 0;
    chk("part_set", 32'(vec_set), 1);
    nb = 0;
    for (int i = 0; i < N; i++) if (vec_out[i] !== (i < 5 ? 8'hA1 + BITS'(i) : 8'h00)) nb++;
    chk("part_lanes", 32'(nb), 0);
    cyc();
    len = 100; start = 1; cyc(); start = 0;
    for (int i = 0; i < 63; i++) begin
      in_data = 8'hFF - BITS'(i); in_valid = 1; cyc();
    end
    chk("clamp_no_early_set", 32'(vec_set), 0);
    chk("clamp_count63", 32'(count), 63);
    in_data = 8'hC1; cyc(); in_valid = 0;
    chk("clamp_set", 32'(vec_set), 1);
    chk("clamp_count", 32'(count), 64);
    chk("clamp_lane63", 32'(vec_out[63]), 32'h0C1);
    cyc();
    len = 8; start = 1; cyc(); start = 0;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h10 + BITS'(i); in_valid = 1; cyc();
    end
    in_data = 8'h13; abort = 1; cyc(); abort = 0; in_valid = 0;
    chk("abort_in_ready", 32'(in_ready), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_lane3", 32'(vec_out[3]), 0);
    chk("abort_lane2", 32'(vec_out[2]), 32'h12);
    cyc();
    chk("abort_pulses", 32'(pulses), 3);
    len = 0; start = 1; cyc(); start = 0;
    chk("restart_cleared", 32'(nonzero_lanes()), 0);
    chk("restart_count", 32'(count), 0);
    for (int i = 0; i < 10; i++) begin
      in_data = 8'h50 + BITS'(i); in_valid = 1; cyc();
    end
    in_valid = 0;
    chk("prerst_count", 32'(count), 10);
    rst = 1; cyc();
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_lanes", 32'(nonzero_lanes()), 0);
    rst = 0; p = pulses;
    for (int i = 0; i < 20; i++) begin
      in_data = BITS'($urandom); in_valid = 1; cyc();
    end
    in_valid = 0;
    chk("midrst_no_set", 32'(pulses), 32'(p));
    len = 3; start = 1; cyc();
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h31 + BITS'(i); in_valid = 1; cyc();
    end
    in_valid = 0;
    chk("ign_set", 32'(vec_set), 1);
    cyc();
    chk("ign_commit_start_busy", 32'(busy), 0);
    chk("ign_commit_start_ready", 32'(in_ready), 0);
    chk("ign_hold_lane0", 32'(vec_out[0]), 32'h31);
    chk("ign_hold_lane2", 32'(vec_out[2]), 32'h33);
    cyc();
    chk("ign_new_load", 32'(in_ready), 1);
    chk("ign_new_cleared", 32'(nonzero_lanes()), 0);
    start = 0; abort = 1; cyc(); abort = 0; cyc();
    chk("total_pulses", 32'(pulses), 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
